// File: rtl/braun_mac_accumulator.sv
// ============================================================================
// Module      : braun_mac_accumulator
// Description : Valid/ready MAC accumulator that sums a run-time count of
//               multiplier products and presents the result on a handshake.
//               Define MAC_SATURATE_EN to saturate on carry instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module braun_mac_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [PROD_W-1:0] p_i,
  input  logic              p_valid_i,
  output logic              p_ready_o,
  output logic [ACC_W-1:0]  acc_o,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic              busy_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     w_sum;

  // Bit ACC_W of the widened sum is the carry out of the accumulator.
  assign w_sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    p_ready_o   = 1'b0;
    acc_valid_o = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = (len_i == '0) ? CNT_W'(1) : len_i;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        p_ready_o = 1'b1;
        if (p_valid_i) begin
          if (w_sum[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef MAC_SATURATE_EN
            acc_d = '1;
`else
            acc_d = w_sum[ACC_W-1:0];
`endif
          end else begin
            acc_d = w_sum[ACC_W-1:0];
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        acc_valid_o = 1'b1;
        if (acc_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_braun_mac_accumulator.sv
// ============================================================================
// Module      : tb_braun_mac_accumulator
// Description : Directed bench driving a 16-bit and a 10-bit accumulator with
//               shared stimulus and hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_braun_mac_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic [7:0]  p;
  logic        p_valid;
  logic        acc_ready;

  logic        p_ready_a, acc_valid_a, busy_a, ovf_a;
  logic [15:0] acc_a;
  logic        p_ready_b, acc_valid_b, busy_b, ovf_b;
  logic [9:0]  acc_b;

  int n_checks;
  int n_errors;

  braun_mac_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .len_i       (len),
    .p_i         (p),
    .p_valid_i   (p_valid),
    .p_ready_o   (p_ready_a),
    .acc_o       (acc_a),
    .acc_valid_o (acc_valid_a),
    .acc_ready_i (acc_ready),
    .busy_o      (busy_a),
    .ovf_o       (ovf_a)
  );

  braun_mac_accumulator #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .len_i       (len),
    .p_i         (p),
    .p_valid_i   (p_valid),
    .p_ready_o   (p_ready_b),
    .acc_o       (acc_b),
    .acc_valid_o (acc_valid_b),
    .acc_ready_i (acc_ready),
    .busy_o      (busy_b),
    .ovf_o       (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] gap_pv;
  logic [7:0] gap_p [7];
  int         sum_a;
  logic [9:0] exp_b_sat;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    len       = 4'd0;
    p         = 8'd0;
    p_valid   = 1'b0;
    acc_ready = 1'b0;
    #1;
    check("rst_acc",       32'(acc_a),       0);
    check("rst_acc_valid", 32'(acc_valid_a), 0);
    check("rst_p_ready",   32'(p_ready_a),   0);
    check("rst_busy",      32'(busy_a),      0);
    check("rst_ovf",       32'(ovf_a),       0);
    tick();
    rst = 1'b0;
    tick();

    // Three back-to-back products of 225
    start = 1'b1; len = 4'd3;
    tick();
    check("t2_busy",    32'(busy_a),    1);
    check("t2_p_ready", 32'(p_ready_a), 1);
    start = 1'b0; p_valid = 1'b1; p = 8'd225;
    tick();
    check("t2_acc1", 32'(acc_a), 225);
    tick();
    check("t2_acc2",   32'(acc_a),       450);
    check("t2_valid2", 32'(acc_valid_a), 0);
    tick();
    p_valid = 1'b0;
    check("t2_valid",   32'(acc_valid_a), 1);
    check("t2_acc",     32'(acc_a),       675);
    check("t2_ovf",     32'(ovf_a),       0);
    check("t2_p_ready", 32'(p_ready_a),   0);
    check("t2_acc_b",   32'(acc_b),       675);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("t2_rel_valid", 32'(acc_valid_a), 0);
    check("t2_rel_busy",  32'(busy_a),      0);
    check("t2_rel_acc",   32'(acc_a),       675);

    // len=0 behaves as a single-product run
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0; p_valid = 1'b1; p = 8'd9;
    tick();
    p_valid = 1'b0;
    check("t3_valid", 32'(acc_valid_a), 1);
    check("t3_acc",   32'(acc_a),       9);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;

    // Gapped p_valid with a spurious start mid-run
    gap_pv = 7'b1011001;
    gap_p[0] = 8'd10; gap_p[1] = 8'd99; gap_p[2] = 8'd98; gap_p[3] = 8'd20;
    gap_p[4] = 8'd30; gap_p[5] = 8'd97; gap_p[6] = 8'd40;
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      p_valid = gap_pv[i];
      p       = gap_p[i];
      start   = (i == 2);
      len     = 4'd1;
      tick();
      if (i == 5) begin
        check("t5_mid_acc",   32'(acc_a),       60);
        check("t5_mid_valid", 32'(acc_valid_a), 0);
      end
    end
    check("t5_acc",   32'(acc_a),       100);
    check("t5_valid", 32'(acc_valid_a), 1);
    check("t5_acc_b", 32'(acc_b),       100);

    // Back-pressure in DONE while inputs keep toggling
    p_valid = 1'b1; p = 8'd55; start = 1'b1; acc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_hold_acc",   32'(acc_a),       100);
      check("t6_hold_valid", 32'(acc_valid_a), 1);
    end
    acc_ready = 1'b1;
    tick();
    check("t6_rel_valid", 32'(acc_valid_a), 0);
    check("t6_rel_busy",  32'(busy_a),      0);
    start = 1'b0; acc_ready = 1'b0; p_valid = 1'b0;
    tick();
    check("t6_idle_busy", 32'(busy_a), 0);

    // Five products of 225: 1125 fits 16 bits, overflows 10 bits
    start = 1'b1; len = 4'd5;
    tick();
    start = 1'b0; p_valid = 1'b1; p = 8'd225;
    for (int i = 0; i < 5; i++) tick();
    p_valid = 1'b0;
    sum_a = 1125;
`ifdef MAC_SATURATE_EN
    exp_b_sat = 10'd1023;
`else
    exp_b_sat = 10'd101;
`endif
    check("t4_acc_a",   32'(acc_a),       32'(sum_a));
    check("t4_ovf_a",   32'(ovf_a),       0);
    check("t4_valid_b", 32'(acc_valid_b), 1);
    check("t4_acc_b",   32'(acc_b),       32'(exp_b_sat));
    check("t4_ovf_b",   32'(ovf_b),       1);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("t4_ovf_hold", 32'(ovf_b), 1);
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    check("t4_ovf_clr", 32'(ovf_b), 0);
    check("t4_acc_clr", 32'(acc_b), 0);
    p_valid = 1'b1; p = 8'd1;
    tick();
    p_valid = 1'b0;
    check("t4_next_acc_b", 32'(acc_b), 1);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;

    // Asynchronous reset in the middle of a run
    start = 1'b1; len = 4'd5;
    tick();
    start = 1'b0; p_valid = 1'b1; p = 8'd7;
    tick();
    tick();
    check("t1_pre_acc", 32'(acc_a), 14);
    rst = 1'b1;
    #1;
    check("t1_acc",     32'(acc_a),       0);
    check("t1_valid",   32'(acc_valid_a), 0);
    check("t1_p_ready", 32'(p_ready_a),   0);
    check("t1_busy",    32'(busy_a),      0);
    tick();
    rst = 1'b0;
    tick();
    check("t1_after_busy", 32'(busy_a), 0);
    check("t1_after_acc",  32'(acc_a),  0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
